// File: rtl/op_sequencer_pkg.sv
// op_sequencer_pkg: shared phase codes, instruction slot-field geometry and
// small helpers used by the sequencer and its slot decoder.
package op_sequencer_pkg;

  typedef enum logic [3:0] {
    PH_IDLE        = 4'd0,
    PH_FETCH       = 4'd1,
    PH_WRITE_IP    = 4'd2,
    PH_READ_COND   = 4'd3,
    PH_READ_COND_P = 4'd4,
    PH_READ_SRC    = 4'd5,
    PH_READ_SRC_P  = 4'd6,
    PH_ALU         = 4'd7,
    PH_WRITE_DST   = 4'd8,
    PH_WRITE_COND  = 4'd9,
    PH_WRITE_SRC   = 4'd10,
    PH_FINISH      = 4'd11
  } phase_e;

  // Slot flag value marking a slot the instruction does not use.
  localparam logic [1:0] FLAGS_UNUSED = 2'b11;
  // Bits below this offset are the opcode; the sequencer never looks at them.
  localparam int SLOT_BASE = 16;

  // Slot s: 0 = cond, 1 = dst, 2+k = source k.
  function automatic int ptr_pos(input int s);
    return SLOT_BASE + s;
  endfunction

  function automatic int flag_pos(input int num_src, input int s);
    return SLOT_BASE + num_src + 2 + 2 * s;
  endfunction

  // Highest set bit of v strictly below lim; result {found, index}.
  // Ascending scan so the last hit (the highest) wins.
  function automatic logic [2:0] pick_below(input logic [3:0] v, input logic [2:0] lim);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 4; i++)
      if (v[i] && (i < int'(lim))) r = {1'b1, 2'(i)};
    return r;
  endfunction

endpackage

// File: rtl/op_slot_decode.sv
// op_slot_decode: splits the instruction word into per-slot used / pointer /
// write-back bits. Purely combinational.
//   command : instruction word
//   used    : slot flags are not the unused code
//   ptr     : slot pointer bit (adds an indirection read phase)
//   wb      : slot flags have odd parity (slot is written back)
module op_slot_decode
  import op_sequencer_pkg::*;
#(
  parameter int NUM_SRC = 2,
  localparam int NS     = NUM_SRC + 2,
  localparam int CMD_W  = 16 + 3 * NS
) (
  input  logic [CMD_W-1:0] command,
  output logic [NS-1:0]    used,
  output logic [NS-1:0]    ptr,
  output logic [NS-1:0]    wb
);

  for (genvar s = 0; s < NS; s++) begin : g_slot
    logic [1:0] flags;
    assign flags   = command[flag_pos(NUM_SRC, s) +: 2];
    assign used[s] = flags != FLAGS_UNUSED;
    assign ptr[s]  = command[ptr_pos(s)];
    assign wb[s]   = ^flags;
  end

  logic unused_opcode;
  assign unused_opcode = ^command[SLOT_BASE-1:0];

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: walks one instruction at a time through its datapath phases
// (fetch, condition read, source reads, ALU, write-backs, finish) and keeps
// completed / skipped instruction counters.
//   clk, rst (async, active low)
//   run        : keep issuing instructions; sampled in IDLE and FINISH only
//   command    : instruction word, stable for the whole instruction
//   cond       : condition operand, valid with step_done in READ_COND(_P)
//   step_done  : datapath finished the current phase
//   abort      : jump to FINISH; that instruction is not counted
//   phase, src_idx, busy, done : registered status
//   instr_cnt, skip_cnt        : wrapping statistics
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  localparam int CMD_W  = 16 + 3 * (NUM_SRC + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [CMD_W-1:0]  command,
  input  logic [DATA_W-1:0] cond,
  input  logic              step_done,
  input  logic              abort,
  output logic [3:0]        phase,
  output logic [1:0]        src_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  skip_cnt
);

  localparam int NS = NUM_SRC + 2;
  localparam logic [1:0] LAST = 2'(NUM_SRC - 1);

  logic [NS-1:0] used, ptr, wb;

  op_slot_decode #(.NUM_SRC(NUM_SRC)) u_dec (
    .command (command),
    .used    (used),
    .ptr     (ptr),
    .wb      (wb)
  );

  // Source views zero-extended to the 4-slot maximum so src_idx indexes them.
  logic [3:0] src_used, src_ptr, src_wb;
  assign src_used = 4'(used[NS-1:2]);
  assign src_ptr  = 4'(ptr[NS-1:2]);
  assign src_wb   = 4'(wb[NS-1:2]);

  logic unused_dst;
  assign unused_dst = ^{used[1], ptr[1], wb[1]};

  phase_e     st, nxt;
  logic [1:0] nxt_idx;
  logic       to_skip, skipped, aborted, finish_exit;
  logic [2:0] pk_lim, pk;

  // Next write-back source: below the current one in WRITE_SRC, else from the top.
  assign pk_lim = (st == PH_WRITE_SRC) ? {1'b0, src_idx} : 3'(NUM_SRC);
  assign pk     = pick_below(src_wb, pk_lim);

  assign finish_exit = (st == PH_FINISH) && step_done && !abort;

  always_comb begin
    nxt     = st;
    nxt_idx = src_idx;
    to_skip = 1'b0;
    if (st != PH_IDLE && abort) begin
      nxt = PH_FINISH;
    end else begin
      case (st)
        PH_IDLE: if (run) nxt = PH_FETCH;
        PH_FETCH: if (step_done) nxt = PH_WRITE_IP;
        PH_WRITE_IP:
          if (step_done) begin
            if (used[0]) nxt = PH_READ_COND;
            else begin nxt = PH_READ_SRC; nxt_idx = LAST; end
          end
        PH_READ_COND:
          if (step_done) begin
            if (ptr[0]) nxt = PH_READ_COND_P;
            else if (cond == '0) begin nxt = PH_FINISH; to_skip = 1'b1; end
            else begin nxt = PH_READ_SRC; nxt_idx = LAST; end
          end
        PH_READ_COND_P:
          if (step_done) begin
            if (cond == '0) begin nxt = PH_FINISH; to_skip = 1'b1; end
            else begin nxt = PH_READ_SRC; nxt_idx = LAST; end
          end
        PH_READ_SRC:
          if (step_done) begin
            if (src_used[src_idx] && src_ptr[src_idx]) nxt = PH_READ_SRC_P;
            else if (src_idx == 2'd0) nxt = PH_ALU;
            else nxt_idx = src_idx - 2'd1;
          end
        PH_READ_SRC_P:
          if (step_done) begin
            if (src_idx == 2'd0) nxt = PH_ALU;
            else begin nxt = PH_READ_SRC; nxt_idx = src_idx - 2'd1; end
          end
        PH_ALU: if (step_done) nxt = PH_WRITE_DST;
        PH_WRITE_DST:
          if (step_done) begin
            if (wb[0]) nxt = PH_WRITE_COND;
            else if (pk[2]) begin nxt = PH_WRITE_SRC; nxt_idx = pk[1:0]; end
            else nxt = PH_FINISH;
          end
        PH_WRITE_COND, PH_WRITE_SRC:
          if (step_done) begin
            if (pk[2]) begin nxt = PH_WRITE_SRC; nxt_idx = pk[1:0]; end
            else nxt = PH_FINISH;
          end
        PH_FINISH: if (step_done) nxt = run ? PH_FETCH : PH_IDLE;
        default: nxt = PH_IDLE;
      endcase
    end
    if (nxt != PH_READ_SRC && nxt != PH_READ_SRC_P && nxt != PH_WRITE_SRC)
      nxt_idx = 2'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= PH_IDLE;
      src_idx   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      instr_cnt <= '0;
      skip_cnt  <= '0;
      skipped   <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      st      <= nxt;
      src_idx <= nxt_idx;
      busy    <= nxt != PH_IDLE;
      done    <= finish_exit;
      if (finish_exit) begin
        if (!aborted) begin
          instr_cnt <= instr_cnt + 1'b1;
          if (skipped) skip_cnt <= skip_cnt + 1'b1;
        end
        skipped <= 1'b0;
        aborted <= 1'b0;
      end else begin
        if (to_skip) skipped <= 1'b1;
        if (st != PH_IDLE && abort) aborted <= 1'b1;
      end
    end
  end

  assign phase = st;

endmodule

// File: tb/tb_op_sequencer.sv
module tb_op_sequencer;
  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;
  localparam int CMD_W   = 16 + 3 * (NUM_SRC + 2);

  // Phase codes in the order the phases are listed.
  localparam logic [3:0] P_IDLE = 4'd0, P_FETCH = 4'd1, P_WIP = 4'd2, P_RC = 4'd3,
                         P_RCP = 4'd4, P_RS = 4'd5, P_RSP = 4'd6, P_ALU = 4'd7,
                         P_WD = 4'd8, P_WC = 4'd9, P_WS = 4'd10, P_FIN = 4'd11;

  logic clk = 1'b0, rst = 1'b0, run = 1'b0, step_done = 1'b0, abort = 1'b0;
  logic [CMD_W-1:0]  command = '0;
  logic [DATA_W-1:0] cond = '0;
  logic [3:0]        phase;
  logic [1:0]        src_idx;
  logic              busy, done;
  logic [CNT_W-1:0]  instr_cnt, skip_cnt;

  int checks = 0, errors = 0;
  logic [CNT_W-1:0] m_instr = '0, m_skip = '0;
  logic [5:0] tr[$];
  logic       tr_skip;

  op_sequencer #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .command(command), .cond(cond),
    .step_done(step_done), .abort(abort), .phase(phase), .src_idx(src_idx),
    .busy(busy), .done(done), .instr_cnt(instr_cnt), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Word layout: {src1 fl, src0 fl, dst fl, cond fl, ptr[3:0], opcode}
  function automatic logic [CMD_W-1:0] mk(input logic [3:0] ptrs, input logic [7:0] flags);
    return {flags, ptrs, 16'hC0DE};
  endfunction

  function automatic logic [1:0] fl(input logic [CMD_W-1:0] c, input int s);
    return c[20 + 2 * s +: 2];
  endfunction

  // Expected {phase, src_idx} sequence for one instruction, built from the rules.
  task automatic build_trace(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] cv);
    tr.delete();
    tr_skip = 1'b0;
    tr.push_back({P_FETCH, 2'd0});
    tr.push_back({P_WIP, 2'd0});
    if (fl(c, 0) != 2'b11) begin
      tr.push_back({P_RC, 2'd0});
      if (c[16]) tr.push_back({P_RCP, 2'd0});
      if (cv == 0) begin
        tr.push_back({P_FIN, 2'd0});
        tr_skip = 1'b1;
        return;
      end
    end
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      tr.push_back({P_RS, 2'(k)});
      if (fl(c, 2 + k) != 2'b11 && c[18 + k]) tr.push_back({P_RSP, 2'(k)});
    end
    tr.push_back({P_ALU, 2'd0});
    tr.push_back({P_WD, 2'd0});
    if (fl(c, 0) == 2'b01 || fl(c, 0) == 2'b10) tr.push_back({P_WC, 2'd0});
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (fl(c, 2 + k) == 2'b01 || fl(c, 2 + k) == 2'b10) tr.push_back({P_WS, 2'(k)});
    tr.push_back({P_FIN, 2'd0});
  endtask

  // Runs one instruction from IDLE with step_done stalled stall% of cycles.
  // run drops right after FETCH, so FINISH must return to IDLE.
  task automatic run_instr(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] cv, input int stall);
    int  pos;
    logic sd;
    command = c;
    cond = cv;
    build_trace(c, cv);
    run = 1'b0;
    step_done = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", phase, P_IDLE);
    chk("done_clr", done, 1'b0);
    run = 1'b1;
    step_done = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    run = 1'b0;
    pos = 0;
    chk("fetch", {phase, src_idx}, tr[0]);
    for (int cyc = 0; cyc < 200 && pos < tr.size(); cyc++) begin
      sd = $urandom_range(0, 99) >= stall;
      step_done = sd;
      @(posedge clk); #1;
      if (sd) pos++;
      if (pos < tr.size()) begin
        chk("trace", {phase, src_idx}, tr[pos]);
        chk("busy", busy, 1'b1);
        chk("done_mid", done, 1'b0);
      end else begin
        m_instr++;
        if (tr_skip) m_skip++;
        chk("exit_idle", phase, P_IDLE);
        chk("done_pulse", done, 1'b1);
        chk("busy_idle", busy, 1'b0);
        chk("instr_cnt", instr_cnt, m_instr);
        chk("skip_cnt", skip_cnt, m_skip);
      end
    end
    if (pos < tr.size()) chk("timeout", pos, tr.size());
    step_done = 1'b0;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    for (int i = 0; i < 20 && phase != p; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1;
    chk("rst_phase", phase, P_IDLE);
    chk("rst_idx", src_idx, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_instr", instr_cnt, 0);
    chk("rst_skip", skip_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed scenarios, step_done every cycle.
    run_instr(mk(4'b0000, 8'h03), 32'd7, 0);   // cond unused, plain
    run_instr(mk(4'b0000, 8'h00), 32'd0, 0);   // cond=0 skip
    run_instr(mk(4'b1001, 8'h00), 32'd5, 0);   // cond ptr + src1 ptr
    run_instr(mk(4'b0000, 8'h11), 32'd3, 0);   // write-back cond and src0
    run_instr(mk(4'b0001, 8'h00), 32'd0, 0);   // skip after indirect cond

    // Abort in ALU: FINISH next, not counted.
    command = mk(4'b0000, 8'h03);
    run = 1'b1; step_done = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    wait_phase(P_ALU);
    chk("ab_alu", phase, P_ALU);
    abort = 1'b1; step_done = 1'b0;
    @(posedge clk); #1;
    chk("ab_fin", phase, P_FIN);
    abort = 1'b0; step_done = 1'b1;
    @(posedge clk); #1;
    chk("ab_exit", phase, P_IDLE);
    chk("ab_done", done, 1'b1);
    chk("ab_instr", instr_cnt, m_instr);
    chk("ab_skip", skip_cnt, m_skip);

    // Run a counted instruction after the abort to see the flag cleared.
    run_instr(mk(4'b0000, 8'h00), 32'd9, 0);

    // Reset in READ_SRC: immediate IDLE, counters cleared, no done.
    command = mk(4'b0000, 8'h03);
    run = 1'b1; step_done = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    wait_phase(P_RS);
    chk("rs_reached", phase, P_RS);
    rst = 1'b0;
    #1;
    chk("ar_phase", phase, P_IDLE);
    chk("ar_idx", src_idx, 2'd0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_instr", instr_cnt, 0);
    m_instr = '0;
    m_skip = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ar_nodone", done, 1'b0);
    chk("ar_hold", phase, P_IDLE);

    // Random instructions with stalls; count passes 2^CNT_W, exercising wrap.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      logic [DATA_W-1:0] cv;
      r = $urandom;
      cv = ($urandom_range(0, 1) == 0) ? '0 : DATA_W'($urandom);
      run_instr(CMD_W'(r), cv, 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1);
  end

endmodule
